// File: rtl/hdb3_pattern_source.sv
// Serial test-pattern source for the HDB3 encoder: PAT_LEN-bit frames sent LSB-first under valid/ready.
// Define SRC_PRBS_EN to build the PRBS-15 (x^15+x^14+1) alternative source selected by mode.
module hdb3_pattern_source #(
    parameter int                 PAT_LEN = 33,
    parameter logic [PAT_LEN-1:0] PATTERN = 33'b1_0001_1100_0000_0011_0000_1100_0010_0001,
    parameter int                 CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             loop,
    input  logic             mode,
    input  logic             ready,
    output logic             data_out,
    output logic             valid,
    output logic             sof,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int               IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt, idx_inc;
    logic             data_nxt, valid_nxt, sof_nxt, done_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             xfer, last, bit_inc;

`ifdef SRC_PRBS_EN
    logic [14:0] lfsr, lfsr_nxt;
    logic        prbs, prbs_nxt;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    assign xfer    = valid && ready;
    assign last    = (idx == LAST);
    assign idx_inc = last ? '0 : idx + 1'b1;

    // Bit that follows the one currently on data_out, whichever source is active.
    always_comb begin
        bit_inc = PATTERN[idx_inc];
`ifdef SRC_PRBS_EN
        if (prbs) bit_inc = lfsr[13];
`endif
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        data_nxt  = data_out;
        valid_nxt = valid;
        sof_nxt   = sof;
        done_nxt  = done;
        cnt_nxt   = frame_cnt;
`ifdef SRC_PRBS_EN
        lfsr_nxt  = lfsr;
        prbs_nxt  = prbs;
`endif
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                sof_nxt   = 1'b0;
                done_nxt  = 1'b0;
                if (en) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                    valid_nxt = 1'b1;
                    sof_nxt   = 1'b1;
                    data_nxt  = PATTERN[0];
`ifdef SRC_PRBS_EN
                    prbs_nxt  = mode;
                    if (mode) begin
                        lfsr_nxt = 15'h7FFF;
                        data_nxt = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
`ifdef SRC_PRBS_EN
                // A bit taken on the abort edge is still consumed from the sequence.
                if (xfer) lfsr_nxt = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
`endif
                if (!en) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    sof_nxt   = 1'b0;
                    idx_nxt   = '0;
                end else if (xfer) begin
                    idx_nxt  = idx_inc;
                    data_nxt = bit_inc;
                    sof_nxt  = last;
                    if (last) begin
                        cnt_nxt = frame_cnt + 1'b1;
                        if (!loop) begin
                            state_nxt = DONE;
                            valid_nxt = 1'b0;
                            sof_nxt   = 1'b0;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                valid_nxt = 1'b0;
                sof_nxt   = 1'b0;
                done_nxt  = 1'b1;
                if (!en) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                sof_nxt   = 1'b0;
                done_nxt  = 1'b0;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            data_out  <= 1'b0;
            valid     <= 1'b0;
            sof       <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
`ifdef SRC_PRBS_EN
            lfsr      <= 15'h7FFF;
            prbs      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            data_out  <= data_nxt;
            valid     <= valid_nxt;
            sof       <= sof_nxt;
            done      <= done_nxt;
            frame_cnt <= cnt_nxt;
`ifdef SRC_PRBS_EN
            lfsr      <= lfsr_nxt;
            prbs      <= prbs_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_hdb3_pattern_source.sv
// Bench for hdb3_pattern_source: directed + random steps against a frame/sequence-level model.
module tb_hdb3_pattern_source;

    localparam int PAT_LEN = 33;
`ifdef SRC_PRBS_EN
    localparam bit PRBS_BUILT = 1'b1;
`else
    localparam bit PRBS_BUILT = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, loop = 1'b0, mode = 1'b0, ready = 1'b0;
    logic data_out, valid, sof, done;
    logic [15:0] frame_cnt;
    logic data_out2, valid2, sof2, done2;
    logic [1:0] frame_cnt2;

    hdb3_pattern_source dut (
        .clk(clk), .rst_n(rst_n), .en(en), .loop(loop), .mode(mode), .ready(ready),
        .data_out(data_out), .valid(valid), .sof(sof), .done(done), .frame_cnt(frame_cnt)
    );

    hdb3_pattern_source #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .loop(loop), .mode(mode), .ready(ready),
        .data_out(data_out2), .valid(valid2), .sof(sof2), .done(done2), .frame_cnt(frame_cnt2)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // Model: 0 idle, 1 running, 2 single-shot finished.
    int   m_st = 0, m_pos = 0, m_frames = 0, m_k = 0;
    bit   m_prbs = 1'b0;
    logic [PAT_LEN-1:0] pat;
    bit   prbs_seq [0:8191];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid", {31'd0, valid}, {31'd0, m_st == 1});
        chk("sof", {31'd0, sof}, {31'd0, m_st == 1 && m_pos == 0});
        chk("done", {31'd0, done}, {31'd0, m_st == 2});
        chk("frame_cnt", {16'd0, frame_cnt}, m_frames % 65536);
        chk("frame_cnt_w2", {30'd0, frame_cnt2}, m_frames % 4);
        chk("valid_w2", {31'd0, valid2}, {31'd0, m_st == 1});
        if (m_st == 1)
            chk("data_out", {31'd0, data_out}, {31'd0, m_prbs ? prbs_seq[m_k % 8192] : pat[m_pos]});
    endtask

    task automatic model_edge(input logic e, input logic l, input logic r, input logic m);
        case (m_st)
            0: if (e) begin
                m_st = 1; m_pos = 0; m_k = 0;
                m_prbs = PRBS_BUILT && m;
            end
            1: if (!e) begin
                m_st = 0; m_pos = 0;
            end else if (r) begin
                m_k++;
                if (m_pos == PAT_LEN - 1) begin
                    m_frames++;
                    m_pos = 0;
                    if (!l) m_st = 2;
                end else m_pos++;
            end
            default: if (!e) m_st = 0;
        endcase
    endtask

    // Called at a negedge: drive, let one rising edge pass, then check at the next negedge.
    task automatic tick(input logic e, input logic l, input logic r, input logic m);
        en = e; loop = l; ready = r; mode = m;
        @(posedge clk);
        model_edge(e, l, r, m);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data", {31'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_sof", {31'd0, sof}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_cnt_w2", {30'd0, frame_cnt2}, 32'd0);
        m_st = 0; m_pos = 0; m_frames = 0; m_k = 0; m_prbs = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        pat = 33'b1_0001_1100_0000_0011_0000_1100_0010_0001;
        for (int i = 0; i < 15; i++) prbs_seq[i] = 1'b1;
        for (int i = 15; i < 8192; i++) prbs_seq[i] = prbs_seq[i-15] ^ prbs_seq[i-14];

        repeat (2) @(negedge clk);
        chk("rst_data", {31'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_sof", {31'd0, sof}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;

        repeat (3) tick(1'b0, 1'b1, 1'b1, 1'b0);
        // Continuous looping at full rate across two frame boundaries.
        repeat (75) tick(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0);

        // Abort after 10 transfers, then restart from bit 0.
        repeat (11) tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("abort_cnt", {16'd0, frame_cnt}, 32'd2);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (5) tick(1'b1, 1'b1, 1'b1, 1'b0);

        // Backpressure pattern 1,0,0,1 over several frames.
        for (int i = 0; i < 140; i++) tick(1'b1, 1'b1, (i % 4 == 0) || (i % 4 == 3), 1'b0);
        repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0);

        // Single shot: 33 valid cycles then done, then back to idle.
        repeat (40) tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("single_done", {31'd0, done}, 32'd1);
        repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("single_idle_done", {31'd0, done}, 32'd0);

        // Enough full frames for the 2-bit counter to wrap.
        repeat (5 * PAT_LEN + 2) tick(1'b1, 1'b1, 1'b1, 1'b0);

        // Random en/loop/ready/mode.
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
        repeat (10) tick(1'b1, 1'b1, 1'b1, 1'b0);
        reset_pulse();

        // PRBS run (mode ignored when not built), then reset mid-frame.
        repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (80) tick(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) tick(1'b1, 1'b1, 1'($urandom), 1'($urandom));
        reset_pulse();
        repeat (3) tick(1'b0, 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
